imem_uart_loader: RTL
=====================

// Module: imem_uart_loader
// PURPOSE
// Boot-time controller for the SoC instruction RAM. When load_imem is high it holds the CPU core,
// takes a byte stream from the UART RX block, packs it into 32-bit little-endian words and writes
// them into the imem write port. At all other times it passes CPU fetch reads straight through to imem.
// This is the in-system replacement for a backdoor preload of the imem.
// PARAMETERS
// IMEM_AW         16         imem word-address width; capacity is 2**IMEM_AW words
// TIMEOUT_CYCLES  1000000    idle cycles allowed between bytes during a load before it aborts
// PORTS
// clk             in   1        system clock
// reset           in   1        synchronous, active-low reset
// load_imem       in   1        level request: high = load imem from UART
// rx_valid        in   1        one-cycle strobe, one per received byte
// rx_data         in   8        received byte
// cpu_imem_rd     in   1        CPU fetch read enable
// cpu_imem_addr   in   IMEM_AW  CPU fetch word address
// imem_en         out  1        imem port enable
// imem_we         out  4        imem byte write enables
// imem_addr       out  IMEM_AW  imem word address
// imem_wdata      out  32       imem write data
// cpu_hold        out  1        holds the core in reset while the loader owns imem
// load_busy       out  1        high in LEN/DATA
// load_done       out  1        high in DONE
// load_err        out  1        sticky error; cleared when the next load starts
// words_loaded    out  IMEM_AW+1  count of words written in the current or last load
// BEHAVIOUR
// - Reset (reset==0 at clk edge): state IDLE; cpu_hold=0, load_busy=0, load_done=0, load_err=0.
//   words_loaded=0, packer empty. Registered imem write outputs: en=0, we=0, addr=0, wdata=0.
// - Frame format: 4-byte little-endian header N (word count), then 4*N data bytes.
//   Each data word is little-endian: the first byte goes to wdata[7:0].
// - IDLE: rx_valid is ignored. load_imem==1 moves to LEN and on the same edge sets cpu_hold=1,
//   clears load_err and words_loaded, and resets the packer.
// - LEN: collect 4 bytes into N.
//   N==0 -> DONE. N > 2**IMEM_AW -> ERR. Otherwise -> DATA.
// - DATA: every 4th byte produces a write on the following cycle:
//   imem_en=1, we=4'hF, addr=words_loaded[IMEM_AW-1:0], wdata=packed word.
//   words_loaded increments on that same cycle.
//   When words_loaded reaches N -> DONE; any rx bytes after that are ignored.
// - Back-to-back rx_valid (every cycle) must be accepted with no byte loss. The packer runs
//   independently of the pending write, so the one-cycle write latency never stalls input.
// - Timeout: a counter clears on every rx_valid and counts in LEN/DATA.
//   Reaching TIMEOUT_CYCLES-1 -> ERR.
// - DONE: load_done=1 and cpu_hold stays 1. load_imem==0 -> IDLE, cpu_hold=0 the next cycle.
// - ERR: load_err=1 and cpu_hold stays 1. load_imem==0 -> IDLE and release hold; load_err remains 1.
// - Abort: load_imem dropping during LEN/DATA -> IDLE, load_err=1. A write already pending in its
//   output cycle still completes; no further writes follow.
// - Arbitration: cpu_hold==0 -> imem_en=cpu_imem_rd, we=0, addr=cpu_imem_addr (combinational mux).
//   cpu_hold==1 -> loader registers drive the port and CPU requests are dropped.
// - Reset mid-load: all state returns to reset values immediately; no partial write is issued.
// STRUCTURE
// - imem_loader_pkg: state enum (IDLE, LEN, DATA, DONE, ERR), header byte count 4, WORD_BYTES=4.
// - Sub-module imem_word_packer: 2-bit byte index plus 32-bit shift/assemble register, with a
//   word_valid pulse and a clear input. It is reused for both the header and the data words.
// - Top level: FSM, timeout counter, word counter, write registers and the output mux.
// TESTING
// 1. Reset: hold reset low 3 cycles -> all outputs 0, cpu_hold=0, and CPU reads pass through.
// 2. load_imem=1, bytes 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 ->
//    write addr0=32'h00000013 and addr1=32'h0000006F, words_loaded=2, load_done=1.
//    Drop load_imem -> cpu_hold=0 the next cycle.
// 3. Header N=0 -> DONE with no imem write. Header N=2**IMEM_AW+1 -> load_err=1 with no write.
// 4. 12 data bytes on consecutive cycles (rx_valid stuck high) -> 3 writes, correct data, no lost bytes.
// 5. Send 5 of 8 data bytes, then idle TIMEOUT_CYCLES (set to 64 in the bench) ->
//    load_err=1 and only word 0 written.
// 6. Drop load_imem after 6 data bytes -> IDLE, load_err=1, 1 word written,
//    and the CPU read mux is restored the next cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART-driven instruction RAM loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int HDR_BYTES  = 4;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; the completed word is
// presented combinationally on the cycle its last byte arrives.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   // Shared by header and data words, so sized for the longer of the two.
   localparam int         NBYTES   = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;
   localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

   logic [1:0]  r_idx;
   logic [31:0] r_word;

   always_ff @(posedge i_clk) begin
      if (!i_reset || i_clear) begin
         r_idx  <= '0;
         r_word <= '0;
      end else if (i_valid) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         r_idx  <= r_idx + 2'd1;
         r_word <= o_word;
      end
   end

   assign o_word       = {i_byte, r_word[31:8]};
   assign o_word_valid = i_valid && (r_idx == LAST_IDX);

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: owns the imem write port while loading a UART frame, otherwise
// passes CPU fetch reads straight through.
module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int IMEM_AW        = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load_imem,
   input  logic               i_rx_valid,
   input  logic [7:0]         i_rx_data,
   input  logic               i_cpu_imem_rd,
   input  logic [IMEM_AW-1:0] i_cpu_imem_addr,
   output logic               o_imem_en,
   output logic [3:0]         o_imem_we,
   output logic [IMEM_AW-1:0] o_imem_addr,
   output logic [31:0]        o_imem_wdata,
   output logic               o_cpu_hold,
   output logic               o_load_busy,
   output logic               o_load_done,
   output logic               o_load_err,
   output logic [IMEM_AW:0]   o_words_loaded
);

   localparam int              TW        = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]   TMO_ONE   = TW'(1);
   localparam logic [IMEM_AW:0] WORD_ONE = (IMEM_AW + 1)'(1);
   localparam logic [32:0]     MAX_WORDS = 33'(1) << IMEM_AW;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [IMEM_AW:0]   r_len;
   logic [IMEM_AW:0]   r_words;
   logic [TW-1:0]      r_tmo;
   logic               r_err;
   logic               r_wr_en;
   logic [IMEM_AW-1:0] r_wr_addr;
   logic [31:0]        r_wr_data;

   logic               w_active;
   logic               w_word_valid;
   logic [31:0]        w_word;
   logic               w_tmo_hit;
   logic               w_len_big;
   logic               w_wr;
   logic               w_start;
   logic               w_set_err;
   logic [IMEM_AW:0]   w_words_inc;

   assign w_active    = (r_state == ST_LEN) || (r_state == ST_DATA);
   assign w_tmo_hit   = w_active && !i_rx_valid && (r_tmo == TMO_LAST);
   assign w_len_big   = {1'b0, w_word} > MAX_WORDS;
   assign w_words_inc = r_words + WORD_ONE;

   imem_word_packer u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (r_state == ST_IDLE),
      .i_valid      (i_rx_valid && w_active),
      .i_byte       (i_rx_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_load_imem) w_state_nxt = ST_LEN;
         ST_LEN: begin
            if (!i_load_imem)          w_state_nxt = ST_IDLE;
            else if (w_word_valid) begin
               if (w_word == '0)       w_state_nxt = ST_DONE;
               else if (w_len_big)     w_state_nxt = ST_ERR;
               else                    w_state_nxt = ST_DATA;
            end else if (w_tmo_hit)    w_state_nxt = ST_ERR;
         end
         ST_DATA: begin
            if (!i_load_imem)                              w_state_nxt = ST_IDLE;
            else if (w_word_valid && w_words_inc == r_len) w_state_nxt = ST_DONE;
            else if (w_tmo_hit)                            w_state_nxt = ST_ERR;
         end
         ST_DONE, ST_ERR: if (!i_load_imem) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // An abort on the same edge as a completed word wins: that word is never written.
   assign w_wr      = (r_state == ST_DATA) && i_load_imem && w_word_valid;
   assign w_start   = (r_state == ST_IDLE) && i_load_imem;
   assign w_set_err = (w_state_nxt == ST_ERR) || (w_active && !i_load_imem);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_len     <= '0;
         r_words   <= '0;
         r_tmo     <= '0;
         r_err     <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_wr;
         if (w_wr) begin
            r_wr_addr <= r_words[IMEM_AW-1:0];
            r_wr_data <= w_word;
            r_words   <= w_words_inc;
         end
         if (w_start) begin
            r_words <= '0;
            r_err   <= 1'b0;
         end else if (w_set_err) begin
            r_err <= 1'b1;
         end
         if (r_state == ST_LEN && w_word_valid) r_len <= w_word[IMEM_AW:0];
         if (!w_active || i_rx_valid) r_tmo <= '0;
         else                         r_tmo <= r_tmo + TMO_ONE;
      end
   end

   assign o_cpu_hold     = (r_state != ST_IDLE);
   assign o_load_busy    = w_active;
   assign o_load_done    = (r_state == ST_DONE);
   assign o_load_err     = r_err;
   assign o_words_loaded = r_words;

   assign o_imem_en    = o_cpu_hold ? r_wr_en        : i_cpu_imem_rd;
   assign o_imem_we    = o_cpu_hold ? {4{r_wr_en}}   : 4'h0;
   assign o_imem_addr  = o_cpu_hold ? r_wr_addr      : i_cpu_imem_addr;
   assign o_imem_wdata = r_wr_data;

endmodule
